// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a request/ready imem port and
// hands {instruction, address} pairs to the IF/ID register, inserting NOPs
// whenever no valid fetched word is available this cycle.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_next,
    output logic [31:0] inst_address_next,
    output logic        fetch_valid
);

    // FETCH: request outstanding at pc.
    // HOLD : word at pc buffered while downstream is stalled.
    // KILL : a redirect arrived under an outstanding request; drain it first.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] tgt_aligned;
    logic [31:0] pc_inc;

    assign tgt_aligned = {redirect_target[31:2], 2'b00};
    assign pc_inc      = pc_q + 32'd4;

    // State, PC and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            buf_q     <= NOP_INST;
            pending_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            buf_q     <= buf_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic and the combinational outputs seen by imem and IF/ID.
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        buf_d             = buf_q;
        pending_d         = pending_q;
        imem_req          = 1'b0;
        imem_addr         = pc_q;
        fetch_valid       = 1'b0;
        instruction_next  = NOP_INST;
        inst_address_next = pc_q;

        if (!rst) begin
            unique case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        if (redirect_valid) begin
                            pc_d = tgt_aligned;
                        end else if (stall) begin
                            buf_d   = imem_rdata;
                            state_d = HOLD;
                        end else begin
                            fetch_valid      = 1'b1;
                            instruction_next = imem_rdata;
                            pc_d             = pc_inc;
                        end
                    end else if (redirect_valid) begin
                        pending_d = tgt_aligned;
                        state_d   = KILL;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        buf_d   = NOP_INST;
                        pc_d    = tgt_aligned;
                        state_d = FETCH;
                    end else if (!stall) begin
                        fetch_valid      = 1'b1;
                        instruction_next = buf_q;
                        pc_d             = pc_inc;
                        state_d          = FETCH;
                    end
                end
                KILL: begin
                    // Address stays at the stale pc until the response drains.
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        pc_d    = redirect_valid ? tgt_aligned : pending_q;
                        state_d = FETCH;
                    end else if (redirect_valid) begin
                        pending_d = tgt_aligned;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule
